// File: rtl/missile_input_pkg.sv
// Shared constants and helpers for the Missile Command input path.
// Covers the trackball count width, input-port bit placement and the default filter depth.
package missile_input_pkg;

    localparam int COUNT_WIDTH           = 4;
    localparam int H_LSB                 = 0;
    localparam int V_LSB                 = 4;
    localparam int FILTER_CYCLES_DEFAULT = 4;

    typedef logic [COUNT_WIDTH-1:0] count_t;

    // Modulo-16 up/down step; wrap comes for free from the 4-bit width.
    function automatic count_t step_count(input count_t cnt, input logic down);
        return down ? count_t'(cnt - 1'b1) : count_t'(cnt + 1'b1);
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: it synchronizes the step clock and direction, then glitch-filters the clock.
// Every accepted level change (either edge) is one step of a wrapping 4-bit up/down counter.
module trackball_axis
    import missile_input_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   step_clk,
    input  logic   dir,
    input  logic   flip,
    output count_t count
);

    localparam logic [3:0] STAB_LAST = 4'(FILTER_CYCLES - 1);

    logic [1:0] clk_sync_q, dir_sync_q;
    logic       filt_q, filt_d;
    logic [3:0] stab_q, stab_d;
    count_t     count_q, count_d;
    logic       clk_s, dir_s, step;

    assign clk_s = clk_sync_q[1];
    assign dir_s = dir_sync_q[1];

    // A new level must differ from the accepted one for FILTER_CYCLES consecutive samples.
    always_comb begin
        filt_d  = filt_q;
        stab_d  = stab_q;
        step    = 1'b0;
        count_d = count_q;
        if (clk_s == filt_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_LAST) begin
            filt_d = clk_s;
            stab_d = '0;
            step   = 1'b1;
        end else begin
            stab_d = stab_q + 4'd1;
        end
        if (step) begin
            count_d = step_count(count_q, dir_s ^ flip);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= '0;
            dir_sync_q <= '0;
            filt_q     <= 1'b0;
            stab_q     <= '0;
            count_q    <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], step_clk};
            dir_sync_q <= {dir_sync_q[0], dir};
            filt_q     <= filt_d;
            stab_q     <= stab_d;
            count_q    <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/trackball_counter.sv
// Missile Command trackball position counter: two independent axis counters feed a snapshot.
// The snapshot holds during CPU reads, and CTRLD muxes it against the switch byte.
module trackball_counter
    import missile_input_pkg::*;
#(
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       h_clk,
    input  logic       h_dir,
    input  logic       v_clk,
    input  logic       v_dir,
    input  logic       flip,
    input  logic       ctrld,
    input  logic [7:0] switches,
    input  logic       rd_strobe,
    output logic [7:0] dout
);

    // Index 0 is the horizontal axis, index 1 the vertical axis.
    logic [1:0] axis_clk, axis_dir;
    count_t     axis_count [2];
    logic [7:0] snap_q, snap_d;

    assign axis_clk = {v_clk, h_clk};
    assign axis_dir = {v_dir, h_dir};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            trackball_axis #(
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_axis (
                .clk      (clk),
                .reset    (reset),
                .step_clk (axis_clk[gi]),
                .dir      (axis_dir[gi]),
                .flip     (flip),
                .count    (axis_count[gi])
            );
        end
    endgenerate

    // Freezing both halves together keeps a CPU read from tearing between axes.
    always_comb begin
        snap_d = snap_q;
        if (!rd_strobe) begin
            snap_d[H_LSB +: COUNT_WIDTH] = axis_count[0];
            snap_d[V_LSB +: COUNT_WIDTH] = axis_count[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snap_q <= '0;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign dout = ctrld ? snap_q : switches;

endmodule

// File: tb/tb_trackball_counter.sv
// Directed and randomized checks of trackball_counter against a step-level reference model.
module tb_trackball_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       h_clk = 1'b0, h_dir = 1'b0, v_clk = 1'b0, v_dir = 1'b0;
    logic       flip = 1'b0, ctrld = 1'b1, rd_strobe = 1'b0;
    logic [7:0] switches = 8'h00;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail   = 0;

    trackball_counter #(.FILTER_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .h_clk     (h_clk),
        .h_dir     (h_dir),
        .v_clk     (v_clk),
        .v_dir     (v_dir),
        .flip      (flip),
        .ctrld     (ctrld),
        .switches  (switches),
        .rd_strobe (rd_strobe),
        .dout      (dout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] expected);
        n_checks++;
        assert (dout === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, dout, expected);
        end
    endtask

    task automatic do_reset();
        h_clk = 1'b0; v_clk = 1'b0; rd_strobe = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
    endtask

    // Reference model: one step per deliberate level change, direction from dir^flip.
    function automatic int model_step(input int cnt, input logic dir, input logic flp);
        return (dir ^ flp) ? (cnt + 15) % 16 : (cnt + 1) % 16;
    endfunction

    int  h_ref, v_ref;
    int  h_act, v_act, h_gl, v_gl;
    logic [7:0] sw;

    initial begin
        // Reset state and switch passthrough.
        switches = 8'hA5; ctrld = 1'b1;
        reset = 1'b1;
        tick(3);
        check("reset_counts", 8'h00);
        ctrld = 1'b0; #1;
        check("reset_switches", 8'hA5);
        ctrld = 1'b1;
        reset = 1'b0;
        tick(1);

        // Increment with exact first-step latency.
        flip = 1'b0; h_dir = 1'b0;
        h_clk = ~h_clk;
        tick(6);
        check("latency_before", 8'h00);
        tick(1);
        check("latency_at", 8'h01);
        tick(13);
        h_clk = ~h_clk; tick(20);
        h_clk = ~h_clk; tick(20);
        check("increment_3", 8'h03);

        // Decrement and wrap on the vertical axis.
        do_reset();
        v_dir = 1'b1;
        v_clk = ~v_clk; tick(20);
        check("dec_wrap", 8'hF0);
        v_clk = ~v_clk; tick(20);
        v_clk = ~v_clk; tick(20);
        check("dec_two_more", 8'hD0);

        // Glitch filter boundary: 3 cycles rejected, 4 accepted.
        do_reset();
        h_dir = 1'b0;
        h_clk = 1'b1; tick(3);
        h_clk = 1'b0; tick(20);
        check("glitch_3", 8'h00);
        h_clk = 1'b1; tick(4);
        h_clk = 1'b0; tick(20);
        check("pulse_4", 8'h02);

        // Flip with simultaneous steps on both axes.
        do_reset();
        flip = 1'b1; h_dir = 1'b0; v_dir = 1'b1;
        tick(2);
        h_clk = ~h_clk; v_clk = ~v_clk; tick(20);
        h_clk = ~h_clk; v_clk = ~v_clk; tick(20);
        check("flip_simul", 8'h2E);

        // Read hold, release, then reset in the middle of a pulse.
        do_reset();
        flip = 1'b0; h_dir = 1'b0;
        rd_strobe = 1'b1;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            h_clk = ~h_clk; tick(10);
        end
        tick(10);
        check("read_frozen", 8'h00);
        rd_strobe = 1'b0;
        tick(1);
        check("read_release", 8'h05);
        h_clk = ~h_clk; tick(2);
        reset = 1'b1; tick(1);
        h_clk = 1'b0; tick(2);
        reset = 1'b0; tick(1);
        check("mid_pulse_reset", 8'h00);
        tick(20);
        check("no_stale_step", 8'h00);

        // Randomized segments checked against the step-level model.
        do_reset();
        h_ref = 0; v_ref = 0;
        for (int s = 0; s < 40; s++) begin
            flip  = 1'($urandom_range(0, 1));
            h_dir = 1'($urandom_range(0, 1));
            v_dir = 1'($urandom_range(0, 1));
            h_act = $urandom_range(0, 2);  // 0 idle, 1 toggle, 2 glitch
            v_act = $urandom_range(0, 2);
            h_gl  = $urandom_range(1, 3);
            v_gl  = $urandom_range(1, 3);
            for (int c = 0; c < 24; c++) begin
                if (c == 2 && h_act != 0) h_clk = ~h_clk;
                if (c == 2 + h_gl && h_act == 2) h_clk = ~h_clk;
                if (c == 2 && v_act != 0) v_clk = ~v_clk;
                if (c == 2 + v_gl && v_act == 2) v_clk = ~v_clk;
                tick(1);
            end
            if (h_act == 1) h_ref = model_step(h_ref, h_dir, flip);
            if (v_act == 1) v_ref = model_step(v_ref, v_dir, flip);
            check($sformatf("rand_seg%0d", s), {4'(v_ref), 4'(h_ref)});
            if (s % 8 == 0) begin
                sw = 8'($urandom);
                switches = sw; ctrld = 1'b0; #1;
                check($sformatf("rand_sw%0d", s), sw);
                ctrld = 1'b1; #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
